mem_access_stage: RTL and testbench

- MEM stage of the pipelined processor. It consumes the EX/MEM pipeline register outputs and drives the data-memory request/ready bus.
- It stalls upstream while a memory access is outstanding, then registers the result into the MEM/WB boundary for writeback.
- It enforces word alignment and a bus timeout. Both errors convert the instruction into a bubble and raise an error pulse.

---
 rtl/mem_access_stage.sv | 121 ++++++++++++
 tb/tb_mem_access_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests from the EX/MEM register,
// stalls upstream while an access is outstanding, and registers the result
// into the MEM/WB boundary. Misaligned accesses and bus timeouts retire as
// bubbles (no register write) and raise a one-cycle error pulse.
module mem_access_stage #(
  parameter int TIMEOUT = 16,  // max wait cycles in ACCESS; 0 disables
  parameter int CNT_W   = 5    // wait counter width, 2**CNT_W > TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inRegWriteEn,
  input  logic [1:0]  inMemtoReg,
  input  logic        inMemWriteEn,
  input  logic        inMemReadEn,
  input  logic [31:0] inpcNext,
  input  logic [31:0] inAluResult,
  input  logic [31:0] inreadData2,
  input  logic [4:0]  inWBAddress,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall,
  output logic        outRegWriteEn,
  output logic [1:0]  outMemtoReg,
  output logic [31:0] outpcNext,
  output logic [31:0] outAluResult,
  output logic [31:0] outMemData,
  output logic [4:0]  outWBAddress,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  // Last wait count before the access is abandoned (unused when TIMEOUT==0).
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] count;

  logic memop;
  logic aligned;
  logic misalign_hit;
  logic timeout_hit;
  logic complete;

  assign memop   = inMemReadEn | inMemWriteEn;
  assign aligned = (inAluResult[1:0] == 2'b00);

  // Reset withdraws the request and stall immediately, even mid-access.
  assign timeout_hit  = reset && (state == ACCESS) && !dmem_ready &&
                        (TIMEOUT != 0) && (count == TO_LAST);
  assign dmem_req     = reset && ((state == ACCESS) || (memop && aligned));
  assign misalign_hit = (state == IDLE) && memop && !aligned;
  assign stall        = dmem_req && !dmem_ready && !timeout_hit;
  assign complete     = dmem_req && dmem_ready;

  // A read/write conflict resolves as a write.
  assign dmem_we    = dmem_req && inMemWriteEn;
  assign dmem_addr  = inAluResult;
  assign dmem_wdata = inreadData2;

  // Next-state selection for the IDLE/ACCESS handshake.
  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (dmem_req && !dmem_ready) state_next = ACCESS;
      ACCESS:  if (dmem_ready || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and wait counter, synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE)
        count <= '0;
      else if (stall)
        count <= count + 1'b1;
    end
  end

  // MEM/WB boundary: bubble while stalled, load (with error overrides) otherwise.
  always_ff @(posedge clock) begin
    if (!reset) begin
      outRegWriteEn <= 1'b0;
      outMemtoReg   <= '0;
      outpcNext     <= '0;
      outAluResult  <= '0;
      outMemData    <= '0;
      outWBAddress  <= '0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else if (stall) begin
      outRegWriteEn <= 1'b0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      outRegWriteEn <= inRegWriteEn && !misalign_hit && !timeout_hit;
      outMemtoReg   <= inMemtoReg;
      outpcNext     <= inpcNext;
      outAluResult  <= inAluResult;
      outMemData    <= (complete && !inMemWriteEn) ? dmem_rdata : '0;
      outWBAddress  <= inWBAddress;
      misalign_err  <= misalign_hit;
      bus_err       <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver pushes the expected
// MEM/WB record for each instruction it presents; a monitor pops and compares
// whenever the stage retires an instruction, and checks bubbles and reset.
module tb_mem_access_stage;

  typedef struct packed {
    logic        reg_write_en;
    logic [1:0]  mem_to_reg;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] pc_next;
    logic [31:0] alu_result;
    logic [31:0] read_data2;
    logic [4:0]  wb_address;
  } op_t;

  typedef struct packed {
    logic        reg_write_en;
    logic [1:0]  mem_to_reg;
    logic [31:0] pc_next;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  wb_address;
    logic        misalign;
    logic        bus;
  } exp_t;

  typedef enum int {M_NONE, M_RESET, M_CAPTURE, M_BUBBLE} mode_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_reg_write_en, in_mem_write_en, in_mem_read_en;
  logic [1:0]  in_mem_to_reg;
  logic [31:0] in_pc_next, in_alu_result, in_read_data2;
  logic [4:0]  in_wb_address;
  logic        dmem_req, dmem_we, dmem_ready, stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        out_reg_write_en, misalign_err, bus_err;
  logic [1:0]  out_mem_to_reg;
  logic [31:0] out_pc_next, out_alu_result, out_mem_data;
  logic [4:0]  out_wb_address;

  int    n_total = 0;
  int    n_bad   = 0;
  exp_t  exp_q[$];
  exp_t  last = '0;
  mode_t mon_mode = M_NONE;

  mem_access_stage #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .inRegWriteEn (in_reg_write_en),
    .inMemtoReg   (in_mem_to_reg),
    .inMemWriteEn (in_mem_write_en),
    .inMemReadEn  (in_mem_read_en),
    .inpcNext     (in_pc_next),
    .inAluResult  (in_alu_result),
    .inreadData2  (in_read_data2),
    .inWBAddress  (in_wb_address),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ready   (dmem_ready),
    .stall        (stall),
    .outRegWriteEn(out_reg_write_en),
    .outMemtoReg  (out_mem_to_reg),
    .outpcNext    (out_pc_next),
    .outAluResult (out_alu_result),
    .outMemData   (out_mem_data),
    .outWBAddress (out_wb_address),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected record when every field loads straight from the inputs.
  function automatic exp_t pass_exp(input op_t op, input logic [31:0] mem_data);
    exp_t e;
    e.reg_write_en = op.reg_write_en;
    e.mem_to_reg   = op.mem_to_reg;
    e.pc_next      = op.pc_next;
    e.alu_result   = op.alu_result;
    e.mem_data     = mem_data;
    e.wb_address   = op.wb_address;
    e.misalign     = 1'b0;
    e.bus          = 1'b0;
    return e;
  endfunction

  task automatic drive_op(input op_t op);
    in_reg_write_en = op.reg_write_en;
    in_mem_to_reg   = op.mem_to_reg;
    in_mem_write_en = op.mem_write_en;
    in_mem_read_en  = op.mem_read_en;
    in_pc_next      = op.pc_next;
    in_alu_result   = op.alu_result;
    in_read_data2   = op.read_data2;
    in_wb_address   = op.wb_address;
  endtask

  // Present one instruction (called at posedge+2). Stall is expected for the
  // first n_stall cycles; ready is raised in cycle ready_at (-1 = never).
  task automatic run_op(input string name, input op_t op, input int n_stall, input int ready_at,
                        input logic [31:0] rdata, input logic exp_req, input exp_t exp);
    drive_op(op);
    exp_q.push_back(exp);
    for (int i = 0; i <= n_stall; i++) begin
      dmem_ready = (i == ready_at);
      dmem_rdata = rdata;
      @(negedge clock);
      check({name, "_stall"}, stall, (i < n_stall));
      check({name, "_req"}, dmem_req, exp_req);
      if (exp_req)
        check({name, "_bus"}, {dmem_we, dmem_addr, dmem_wdata},
              {op.mem_write_en, op.alu_result, op.read_data2});
      @(posedge clock);
      #2;
    end
    dmem_ready = 1'b0;
  endtask

  // Classify the coming edge while inputs are stable.
  always @(negedge clock) begin
    if (!reset)     mon_mode = M_RESET;
    else if (stall) mon_mode = M_BUBBLE;
    else            mon_mode = M_CAPTURE;
  end

  // Monitor: compare the MEM/WB registers just after each edge.
  always @(posedge clock) begin
    exp_t act;
    exp_t e;
    #1;
    act = {out_reg_write_en, out_mem_to_reg, out_pc_next, out_alu_result,
           out_mem_data, out_wb_address, misalign_err, bus_err};
    case (mon_mode)
      M_RESET: begin
        check("reset_outputs", act, '0);
        last = '0;
      end
      M_BUBBLE: begin
        e = last;
        e.reg_write_en = 1'b0;
        e.misalign     = 1'b0;
        e.bus          = 1'b0;
        check("bubble_outputs", act, e);
      end
      M_CAPTURE: begin
        check("queue_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("retire_record", act, e);
          last = e;
        end
      end
      default: ;
    endcase
  end

  op_t  op;
  exp_t e;

  initial begin
    reset      = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    // Reset held for two cycles with arbitrary inputs.
    for (int i = 0; i < 2; i++) begin
      op = '{1'b1, 2'($urandom_range(0, 2)), 1'($urandom), 1'b1, $urandom,
             {$urandom_range(0, 65535), 16'h0}, $urandom, 5'($urandom)};
      drive_op(op);
      dmem_ready = 1'($urandom);
      dmem_rdata = $urandom;
      @(negedge clock);
      check("reset_req", dmem_req, 1'b0);
      check("reset_stall", stall, 1'b0);
      @(posedge clock);
      #2;
    end
    reset = 1'b1;
    dmem_ready = 1'b0;

    // ALU op straight through.
    op = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h1004, 32'h1234, 32'h0, 5'd5};
    run_op("alu", op, 0, -1, 32'h0, 1'b0, pass_exp(op, 32'h0));

    // Zero-wait load.
    op = '{1'b1, 2'b01, 1'b0, 1'b1, 32'h1008, 32'h100, 32'h0, 5'd6};
    run_op("load0", op, 0, 0, 32'hDEADBEEF, 1'b1, pass_exp(op, 32'hDEADBEEF));

    // Store with three wait cycles; read data on the bus must be ignored.
    op = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h100C, 32'h200, 32'hCAFE, 5'd0};
    run_op("store3", op, 3, 3, 32'h11111111, 1'b1, pass_exp(op, 32'h0));

    // Misaligned load: no request, error pulse, write suppressed.
    op = '{1'b1, 2'b01, 1'b0, 1'b1, 32'h1010, 32'h102, 32'h0, 5'd7};
    e = pass_exp(op, 32'h0);
    e.reg_write_en = 1'b0;
    e.misalign     = 1'b1;
    run_op("misalign", op, 0, -1, 32'h0, 1'b0, e);

    // Non-memory op with a stray ready: pulse drops, read data not captured.
    op = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h1014, 32'hABCD0000, 32'h0, 5'd8};
    run_op("stray", op, 0, 0, 32'hFFFFFFFF, 1'b0, pass_exp(op, 32'h0));

    // Back-to-back: load with one wait, then read/write conflict.
    op = '{1'b1, 2'b01, 1'b0, 1'b1, 32'h1018, 32'h104, 32'h0, 5'd9};
    run_op("load1", op, 1, 1, 32'h12345678, 1'b1, pass_exp(op, 32'h12345678));
    op = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h101C, 32'h108, 32'h77, 5'd0};
    run_op("conflict", op, 0, 0, 32'h5555, 1'b1, pass_exp(op, 32'h0));

    // Timeout: four stalled cycles, then bus_err and suppressed write.
    op = '{1'b1, 2'b01, 1'b0, 1'b1, 32'h1020, 32'h400, 32'h0, 5'd10};
    e = pass_exp(op, 32'h0);
    e.reg_write_en = 1'b0;
    e.bus          = 1'b1;
    run_op("timeout", op, 4, -1, 32'h9999, 1'b1, e);

    // Following op sees the error pulse cleared.
    op = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h1024, 32'h1, 32'h0, 5'd11};
    run_op("after_to", op, 0, -1, 32'h0, 1'b0, pass_exp(op, 32'h0));

    // Reset during the second ACCESS wait cycle aborts the load silently.
    op = '{1'b1, 2'b01, 1'b0, 1'b1, 32'h1028, 32'h300, 32'h0, 5'd12};
    drive_op(op);
    dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("abort_wait_stall", stall, 1'b1);
      check("abort_wait_req", dmem_req, 1'b1);
      @(posedge clock);
      #2;
    end
    reset = 1'b0;
    @(negedge clock);
    check("abort_req", dmem_req, 1'b0);
    check("abort_stall", stall, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b1;

    // Fresh load with two waits starts cleanly from IDLE.
    op = '{1'b1, 2'b01, 1'b0, 1'b1, 32'h102C, 32'h304, 32'h0, 5'd13};
    run_op("fresh", op, 2, 2, 32'hA5A5A5A5, 1'b1, pass_exp(op, 32'hA5A5A5A5));

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
